// File: rtl/mem_stage_unit.sv
// MEM-stage responder: load/store against a word-organised data memory plus a
// full-descending hardware stack sharing the same array, behind a fixed-latency handshake.
module mem_stage_unit #(
   parameter  int DEPTH     = 64,
   parameter  int ADDR_BASE = 1024,
   parameter  int LATENCY   = 2,
   localparam int SPW       = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           memRead,
   input  logic           memWrite,
   input  logic           pushEn,
   input  logic           popEn,
   input  logic [31:0]    ALUResult,
   input  logic [31:0]    reg2Val,
   output logic [31:0]    readData,
   output logic           freeze,
   output logic [SPW-1:0] sp,
   output logic           stackFull,
   output logic           stackEmpty,
   output logic           memError
);
   localparam int IDXW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

   state_t          state, state_nx;
   op_t             op_in, op_q;
   logic [3:0]      cnt;
   logic [31:0]     addr_q, data_q;
   logic [31:0]     mem [DEPTH];
   logic            request, accept, commit;
   logic [29:0]     word_off;
   logic            addr_bad, op_err;
   logic [IDXW-1:0] idx, push_idx, pop_idx, mem_wa;
   logic            mem_we;
   logic [31:0]     mem_wd;

   assign request = memRead | memWrite | pushEn | popEn;

   always_comb begin
      op_in = OP_STORE;
      if (popEn)        op_in = OP_POP;
      else if (pushEn)  op_in = OP_PUSH;
      else if (memRead) op_in = OP_LOAD;
   end

   // FSM: next state and the stall output
   always_comb begin
      state_nx = state;
      freeze   = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               state_nx = BUSY;
               freeze   = 1'b1;
            end
         end
         BUSY: begin
            freeze = 1'b1;
            if (cnt == 4'd0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && request;
   assign commit = (state == BUSY) && (cnt == 4'd0);

   // Operands are captured at accept so the commit never depends on upstream timing.
   assign word_off = 30'((addr_q - 32'(ADDR_BASE)) >> 2);
   assign addr_bad = (addr_q < 32'(ADDR_BASE)) || (addr_q[1:0] != 2'b00) ||
                     (word_off >= 30'(DEPTH));
   assign idx      = word_off[IDXW-1:0];
   assign push_idx = IDXW'(sp - 1'b1);
   assign pop_idx  = IDXW'(sp);

   assign stackFull  = (sp == '0);
   assign stackEmpty = (sp == SPW'(DEPTH));

   always_comb begin
      op_err = 1'b0;
      case (op_q)
         OP_LOAD, OP_STORE: op_err = addr_bad;
         OP_PUSH:           op_err = stackFull;
         OP_POP:            op_err = stackEmpty;
         default:           op_err = 1'b0;
      endcase
   end

   always_comb begin
      mem_we = 1'b0;
      mem_wa = idx;
      mem_wd = data_q;
      if (commit) begin
         if (op_q == OP_STORE && !addr_bad) mem_we = 1'b1;
         if (op_q == OP_PUSH && !stackFull) begin
            mem_we = 1'b1;
            mem_wa = push_idx;
         end
      end
   end

   // Array is deliberately not reset; reset forces IDLE, so an aborted access never writes.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= OP_LOAD;
         addr_q   <= '0;
         data_q   <= '0;
         sp       <= SPW'(DEPTH);
         readData <= '0;
         memError <= 1'b0;
      end else begin
         state    <= state_nx;
         memError <= commit && op_err;
         if (accept) begin
            cnt    <= 4'(LATENCY - 1);
            op_q   <= op_in;
            addr_q <= ALUResult;
            data_q <= reg2Val;
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 1'b1;
         end
         if (commit) begin
            case (op_q)
               OP_LOAD: readData <= addr_bad ? 32'd0 : mem[idx];
               OP_PUSH: if (!stackFull) sp <= sp - 1'b1;
               OP_POP: begin
                  if (stackEmpty) begin
                     readData <= 32'd0;
                  end else begin
                     readData <= mem[pop_idx];
                     sp       <= sp + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
